// File: rtl/module_display_scheduler.sv
// Time-multiplexes one shared 7-segment bus between a left (word) and right (error) digit,
// with a blanking gap before each slot. Optional build macro: DED_BLINK_EN (blink right digit on double error).
module module_display_scheduler #(
  parameter int         SLOT_CYCLES  = 27000,
  parameter int         BLANK_CYCLES = 270,
  parameter logic [6:0] SEG_OFF      = 7'h7F,
  parameter int         BLINK_FRAMES = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] seg_word,
  input  logic [6:0] seg_error,
  input  logic       err_ded,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick,
  output logic [1:0] state_dbg
);

  localparam int MAX_D = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CW    = $clog2(MAX_D + 1);
  localparam logic [CW-1:0] SLOT_LD  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LD = (BLANK_CYCLES == 0) ? '0 : CW'(BLANK_CYCLES - 1);
  localparam bit HAS_GAP = (BLANK_CYCLES > 0);

  typedef enum logic [1:0] {
    BLANK_L = 2'd0,
    SHOW_L  = 2'd1,
    BLANK_R = 2'd2,
    SHOW_R  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [6:0]    seg_n;
  logic [1:0]    an_n;
  logic [6:0]    right_pat;

  assign state_dbg = state;

`ifdef DED_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] frame_cnt;
  logic          blink_ph;

  // The right digit goes dark during the "off" half of the blink while a double error is flagged.
  assign right_pat = (err_ded && blink_ph) ? SEG_OFF : seg_error;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (frame_tick) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = err_ded ^ (BLINK_FRAMES > 0);
  assign right_pat  = seg_error;
`endif

  // Ticks only while scanning; a park or reset in the last SHOW_R cycle suppresses it.
  assign frame_tick = en && !rst && (state == SHOW_R) && (cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    seg_n   = seg;
    an_n    = an;
    if (!en) begin
      state_n = BLANK_L;
      cnt_n   = BLANK_LD;
      seg_n   = SEG_OFF;
      an_n    = 2'b00;
    end else if (cnt == '0) begin
      case (state)
        BLANK_L: begin
          state_n = SHOW_L;
          cnt_n   = SLOT_LD;
          seg_n   = seg_word;
          an_n    = 2'b10;
        end
        SHOW_L: begin
          if (HAS_GAP) begin
            state_n = BLANK_R;
            cnt_n   = BLANK_LD;
            seg_n   = SEG_OFF;
            an_n    = 2'b00;
          end else begin
            state_n = SHOW_R;
            cnt_n   = SLOT_LD;
            seg_n   = right_pat;
            an_n    = 2'b01;
          end
        end
        BLANK_R: begin
          state_n = SHOW_R;
          cnt_n   = SLOT_LD;
          seg_n   = right_pat;
          an_n    = 2'b01;
        end
        default: begin
          if (HAS_GAP) begin
            state_n = BLANK_L;
            cnt_n   = BLANK_LD;
            seg_n   = SEG_OFF;
            an_n    = 2'b00;
          end else begin
            state_n = SHOW_L;
            cnt_n   = SLOT_LD;
            seg_n   = seg_word;
            an_n    = 2'b10;
          end
        end
      endcase
    end else begin
      cnt_n = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK_L;
      cnt   <= '0;
      seg   <= SEG_OFF;
      an    <= 2'b00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      seg   <= seg_n;
      an    <= an_n;
    end
  end

endmodule
